// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: TX FIFO read port between the FIFO (master) and the serializer (slave)
//   fifo_empty : FIFO empty flag, driven by the FIFO
//   fifo_data  : first-word fall-through head word, valid while fifo_empty=0
//   fifo_read  : one-cycle pop strobe, driven by the serializer
interface uart_tx_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_read;
    modport master (output fifo_empty, fifo_data, input fifo_read);
    modport slave  (input fifo_empty, fifo_data, output fifo_read);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: drains the TX FIFO and serializes each word as a start/data/stop frame
//   i_clock     : system clock, rising edge
//   i_reset     : asynchronous active-low reset
//   i_tick      : 16x baud tick, one-cycle pulse
//   fifo        : FIFO read port (empty, head data, pop strobe)
//   o_tx        : registered serial line, idle high
//   o_busy      : high while a frame is in progress
//   o_done_tick : one-cycle pulse after the last stop tick
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int SB_TICKS   = 16
) (
    input  logic           i_clock,
    input  logic           i_reset,
    input  logic           i_tick,
    uart_tx_fifo_if.slave  fifo,
    output logic           o_tx,
    output logic           o_busy,
    output logic           o_done_tick
);
    localparam int NW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t                state, state_nx;
    logic [4:0]            s, s_nx;
    logic [NW-1:0]         n, n_nx;
    logic [DATA_WIDTH-1:0] b, b_nx;
    logic                  tx_nx, done_nx;
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state       <= IDLE;
            s           <= '0;
            n           <= '0;
            b           <= '0;
            o_tx        <= 1'b1;
            o_done_tick <= 1'b0;
        end else begin
            state       <= state_nx;
            s           <= s_nx;
            n           <= n_nx;
            b           <= b_nx;
            o_tx        <= tx_nx;
            o_done_tick <= done_nx;
        end
    end
    always_comb begin
        state_nx = state;
        s_nx     = s;
        n_nx     = n;
        b_nx     = b;
        done_nx  = 1'b0;
        case (state)
            IDLE: if (fifo.fifo_read) begin
                b_nx     = fifo.fifo_data;
                s_nx     = '0;
                state_nx = START;
            end
            START: if (i_tick) begin
                if (s == 5'd15) begin
                    s_nx     = '0;
                    n_nx     = '0;
                    state_nx = DATA;
                end else s_nx = s + 5'd1;
            end
            DATA: if (i_tick) begin
                if (s == 5'd15) begin
                    s_nx = '0;
                    b_nx = b >> 1;
                    if (n == NW'(DATA_WIDTH - 1)) state_nx = STOP;
                    else n_nx = n + NW'(1);
                end else s_nx = s + 5'd1;
            end
            STOP: if (i_tick) begin
                if (s == 5'(SB_TICKS - 1)) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else s_nx = s + 5'd1;
            end
            default: state_nx = IDLE;
        endcase
        // line level is registered from the next state so it changes on the same edge as the state
        tx_nx = state_nx == START ? 1'b0 : state_nx == DATA ? b_nx[0] : 1'b1;
    end
    always_comb begin
        fifo.fifo_read = (state == IDLE) & ~fifo.fifo_empty & i_reset;
        o_busy         = state != IDLE;
    end
endmodule
